// File: rtl/tm1638_responder.sv
// TM1638 slave emulator: decodes host command/address/data frames into a
// 16-byte display RAM and display-control state, and serves 32-bit key scans.
module tm1638_responder #(
  parameter int sync_stages = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sio_stb,
  input  logic         sio_clk,
  input  logic         sio_data_in,
  output logic         sio_data_out,
  output logic         sio_data_oe,
  input  logic [7:0]   keys,
  output logic [127:0] ram,
  output logic         display_on,
  output logic [2:0]   brightness,
  output logic         frame_error
);

  localparam int SS = (sync_stages < 2) ? 2 : sync_stages;
  localparam int FW = $clog2(SS + 2) + 1;
  localparam logic [FW-1:0] FLUSH = FW'(SS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_IGNORE = 3'd4;

  logic [SS-1:0] r_stb_s, r_clk_s, r_dat_s;
  logic          r_stb_d, r_clk_d;
  logic [FW-1:0] r_flush;
  logic [2:0]    r_state;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic [3:0]    r_ptr;
  logic          r_fixed;
  logic          r_wr_pend;
  logic [7:0]    r_wr_byte;
  logic [127:0]  r_ram;
  logic          r_disp_on;
  logic [2:0]    r_bright;
  logic          r_ferr;
  logic [31:0]   r_keyw;
  logic [4:0]    r_ridx;
  logic          r_oe;
  logic          r_rd_done;

  logic        w_stb, w_clk, w_dat, w_live;
  logic        w_stb_fall, w_stb_rise, w_clk_rise, w_clk_fall;
  logic        w_shifting, w_done;
  logic [7:0]  w_byte;
  logic [31:0] w_keyw;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stb_s <= '1;
      r_clk_s <= '1;
      r_dat_s <= '1;
    end else begin
      r_stb_s <= {r_stb_s[SS-2:0], sio_stb};
      r_clk_s <= {r_clk_s[SS-2:0], sio_clk};
      r_dat_s <= {r_dat_s[SS-2:0], sio_data_in};
    end
  end

  assign w_stb = r_stb_s[SS-1];
  assign w_clk = r_clk_s[SS-1];
  assign w_dat = r_dat_s[SS-1];

  // Edges are masked until the reset-loaded 1s have flushed out, so a strobe
  // already low at reset release is not mistaken for a frame start.
  assign w_live     = (r_flush == FLUSH);
  assign w_stb_fall = w_live & r_stb_d & ~w_stb;
  assign w_stb_rise = w_live & ~r_stb_d & w_stb;
  assign w_clk_rise = w_live & ~r_clk_d & w_clk & ~w_stb_fall;
  assign w_clk_fall = w_live & r_clk_d & ~w_clk & ~w_stb_fall;

  assign w_byte     = {w_dat, r_shift[7:1]};
  assign w_shifting = w_clk_rise &
                      ((r_state == S_CMD) | (r_state == S_WRITE) | (r_state == S_IGNORE));
  assign w_done     = w_shifting & (r_bitcnt == 3'd7);

  always_comb begin
    w_keyw = '0;
    for (int i = 0; i < 4; i++) begin
      w_keyw[8*i]     = keys[i];
      w_keyw[8*i + 4] = keys[i + 4];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stb_d   <= 1'b1;
      r_clk_d   <= 1'b1;
      r_flush   <= '0;
      r_state   <= S_IDLE;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_fixed   <= 1'b0;
      r_wr_pend <= 1'b0;
      r_wr_byte <= '0;
      r_ram     <= '0;
      r_disp_on <= 1'b0;
      r_bright  <= '0;
      r_ferr    <= 1'b0;
      r_keyw    <= '0;
      r_ridx    <= '0;
      r_oe      <= 1'b0;
      r_rd_done <= 1'b0;
    end else begin
      r_stb_d   <= w_stb;
      r_clk_d   <= w_clk;
      if (!w_live) r_flush <= r_flush + 1'b1;
      r_ferr    <= 1'b0;
      r_wr_pend <= 1'b0;

      if (r_wr_pend) begin
        r_ram[{r_ptr, 3'b000} +: 8] <= r_wr_byte;
        if (!r_fixed) r_ptr <= r_ptr + 4'd1;
      end

      if (w_stb_rise) begin
        r_state   <= S_IDLE;
        r_bitcnt  <= '0;
        r_oe      <= 1'b0;
        r_ridx    <= '0;
        r_rd_done <= 1'b0;
        if (r_bitcnt != 3'd0) r_ferr <= 1'b1;
      end else if (w_stb_fall) begin
        r_state   <= S_CMD;
        r_bitcnt  <= '0;
        r_oe      <= 1'b0;
        r_ridx    <= '0;
        r_rd_done <= 1'b0;
      end else begin
        if (w_shifting) begin
          r_shift  <= w_byte;
          r_bitcnt <= r_bitcnt + 3'd1;
        end
        if (w_done) begin
          case (r_state)
            S_CMD: begin
              case (w_byte[7:6])
                2'b01: begin
                  r_fixed <= w_byte[2];
                  if (w_byte[1:0] == 2'b10) begin
                    r_state <= S_READ;
                    r_keyw  <= w_keyw;
                  end else begin
                    r_state <= S_IGNORE;
                  end
                end
                2'b11: begin
                  r_ptr   <= w_byte[3:0];
                  r_state <= S_WRITE;
                end
                2'b10: begin
                  r_disp_on <= w_byte[3];
                  r_bright  <= w_byte[2:0];
                  r_state   <= S_IGNORE;
                end
                default: begin
                  r_ferr  <= 1'b1;
                  r_state <= S_IGNORE;
                end
              endcase
            end
            S_WRITE: begin
              r_wr_pend <= 1'b1;
              r_wr_byte <= w_byte;
            end
            default: ;
          endcase
        end
        // First fall enables the driver at bit 0; the fall after bit 31 releases it.
        if (w_clk_fall && (r_state == S_READ)) begin
          if (!r_oe && !r_rd_done) begin
            r_oe   <= 1'b1;
            r_ridx <= '0;
          end else if (r_oe) begin
            if (r_ridx == 5'd31) begin
              r_oe      <= 1'b0;
              r_rd_done <= 1'b1;
            end else begin
              r_ridx <= r_ridx + 5'd1;
            end
          end
        end
      end
    end
  end

  assign sio_data_oe  = r_oe;
  assign sio_data_out = r_oe ? r_keyw[r_ridx] : 1'b1;
  assign ram          = r_ram;
  assign display_on   = r_disp_on;
  assign brightness   = r_bright;
  assign frame_error  = r_ferr;

endmodule
